reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Parametrised multi-channel reset sequencer; the successor to the single-output reset synchronizer. It synchronizes an external asynchronous reset request and accepts a synchronous software request. It asserts CHANNELS reset outputs together and holds them for a programmable minimum time. It then releases them one at a time, lowest index first, with a programmable gap. Sits at the top of each clock domain, driving per-subsystem resets (e.g. bus fabric, then peripherals, then cores).

## Interface
- STAGES, 2: synchronizer flop count for async_rst_i; legal ≥2.
- CHANNELS, 4: number of reset outputs; legal ≥1.
- HOLD, 8: cycles all outputs stay asserted after the request drops; legal ≥1.
- GAP, 4: cycles between successive channel releases; legal ≥1.
- clk  input  1  sole clock; all logic rising-edge.
- rst_i  input  1  synchronous, active-high reset of the sequencer itself.
- async_rst_i  input  1  asynchronous reset request, active-high, level.
- sw_rst_i  input  1  synchronous reset request, active-high, level or 1-cycle pulse.
- ack_i  input  CHANNELS  per-channel release acknowledge; present only with RESET_SEQ_ACK_EN.
- rst_o  output  CHANNELS  active-high resets, registered; bit k released k-th.
- busy_o  output  1  high whenever state ≠ IDLE, registered.
- done_o  output  1  one-cycle pulse when the sequence completes, registered.

## Operation
- req = last synchronizer flop OR sw_rst_i.
- States: IDLE, ASSERT, RELEASE (idx = channel being waited on, cnt = cycle counter).
- IDLE: rst_o = 0. req=1 → ASSERT, rst_o ← all ones, cnt ← 0.
- ASSERT: while req=1, cnt held at 0. While req=0, cnt increments. When cnt = HOLD−1: rst_o[0] ← 0, idx ← 1, cnt ← 0, → RELEASE. If CHANNELS=1, go to IDLE instead and pulse done_o.
- RELEASE: cnt increments, saturating at GAP−1. When cnt = GAP−1, rst_o[idx] ← 0, idx++, cnt ← 0.
- After the last channel is released → IDLE; done_o = 1 for the following cycle.
- req=1 in any state (including the release cycle) takes priority: rst_o ← all ones, cnt ← 0, → ASSERT. done_o is suppressed.
- rst_i=1 (highest priority): synchronizer flops ← 0, rst_o ← all ones, busy_o ← 1, done_o ← 0, state ASSERT, cnt ← 0. This makes reset outputs safe from power-up.
- Counter width is $clog2(max(HOLD,GAP)+1); no wrap-around is possible.

## Timing
- Reset values: rst_o = all ones, busy_o = 1, done_o = 0.
- sw_rst_i high at edge n → rst_o all ones after edge n (latency 1).
- async_rst_i stable high before edge n → rst_o all ones after edge n+STAGES.
- First cycle with req=0 sampled at edge m → rst_o[0] falls after edge m+HOLD−1.
- rst_o[k] falls GAP cycles after rst_o[k−1].
- done_o is high in the cycle after rst_o reaches 0; busy_o falls in that same cycle.
- Outputs never glitch: every output is a single flop.

## Configuration
- RESET_SEQ_ACK_EN defined: ack_i is present. The release of channel idx additionally requires ack_i[idx−1]=1. cnt saturates at GAP−1 while waiting; release occurs on the first edge both conditions hold. ack_i has no effect in ASSERT or IDLE.
- Undefined: no ack_i port; release is purely time-based.

## Structure
- Package reset_seq_pkg: state enum (IDLE, ASSERT, RELEASE) and a max() constant function for the counter width.
- One sub-module: sync_chain (STAGES-deep flop chain, synchronous reset to 0), instantiated once for async_rst_i.
- reset_seq_ctrl top: FSM, cnt, idx, output registers.

## Test plan
Bench uses STAGES=2, CHANNELS=4, HOLD=8, GAP=4.
- rst_i high 3 cycles, then low → rst_o=4'hF and busy_o=1 during reset. rst_o = 4'hE, 4'hC, 4'h8, 4'h0 at 8, 12, 16, 20 cycles after the first low cycle. done_o pulses once at cycle 21.
- From IDLE, 1-cycle sw_rst_i → rst_o=4'hF the next cycle, then the same release cadence as above.
- From IDLE, async_rst_i high for 1.5 periods mid-cycle → rst_o=4'hF exactly STAGES edges after the first sampling edge. The release sequence then follows.
- sw_rst_i pulse while rst_o=4'hC → rst_o=4'hF next cycle. A full HOLD restarts, and no done_o pulse from the aborted sequence.
- rst_i pulse during RELEASE → rst_o=4'hF and the sequence restarts identically to the first test.
- With RESET_SEQ_ACK_EN: ack_i=4'b0001 → rst_o stalls at 4'hC. Raising ack_i[1] 20 cycles later → rst_o=4'h8 after the next edge.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the multi-channel reset sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {IDLE, ASSERT, RELEASE} state_t;

  function automatic int max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_sequencer_sync_chain.sv
// STAGES-deep synchronizer for a level request; clears to 0 on synchronous reset.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (rst) ff <= '0;
    else     ff <= {ff[STAGES-2:0], din};
  end

  assign dout = ff[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Multi-channel reset sequencer: assert all, hold HOLD cycles, release lowest-first every GAP cycles.
// Optional RESET_SEQ_ACK_EN adds ack_i gating of each channel release after the first.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int STAGES   = 2,
  parameter int CHANNELS = 4,
  parameter int HOLD     = 8,
  parameter int GAP      = 4
) (
  input  logic                clk,
  input  logic                rst_i,
  input  logic                async_rst_i,
  input  logic                sw_rst_i,
`ifdef RESET_SEQ_ACK_EN
  input  logic [CHANNELS-1:0] ack_i,
`endif
  output logic [CHANNELS-1:0] rst_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam int CW = $clog2(max(HOLD, GAP) + 1);
  localparam int IW = $clog2(CHANNELS + 1);
  localparam logic [CW-1:0] HOLD_END = CW'(HOLD - 1);
  localparam logic [CW-1:0] GAP_END  = CW'(GAP - 1);
  localparam logic [IW-1:0] LAST     = IW'(CHANNELS - 1);

  state_t                state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [IW-1:0]         idx, idx_n;
  logic [CHANNELS-1:0]   rst_n;
  logic                  async_req, req, ack_ok;

  sync_chain #(.STAGES(STAGES)) u_sync (
    .clk  (clk),
    .rst  (rst_i),
    .din  (async_rst_i),
    .dout (async_req)
  );

  assign req = async_req | sw_rst_i;

  // Channel idx waits on the acknowledge of the channel released just before it.
  always_comb begin
`ifdef RESET_SEQ_ACK_EN
    ack_ok = 1'b0;
    for (int k = 0; k < CHANNELS; k++)
      if (idx == IW'(k + 1)) ack_ok = ack_i[k];
`else
    ack_ok = 1'b1;
`endif
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    rst_n   = rst_o;
    if (req) begin
      state_n = ASSERT;
      cnt_n   = '0;
      rst_n   = '1;
    end else begin
      case (state)
        IDLE: rst_n = '0;
        ASSERT: begin
          if (cnt == HOLD_END) begin
            rst_n[0] = 1'b0;
            cnt_n    = '0;
            idx_n    = IW'(1);
            state_n  = (CHANNELS == 1) ? IDLE : RELEASE;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (cnt == GAP_END && ack_ok) begin
            for (int k = 0; k < CHANNELS; k++)
              if (idx == IW'(k)) rst_n[k] = 1'b0;
            cnt_n = '0;
            idx_n = idx + 1'b1;
            if (idx == LAST) state_n = IDLE;
          end else if (cnt != GAP_END) begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: state_n = ASSERT;
      endcase
    end
  end

  // done_o fires on the first IDLE cycle that follows a non-IDLE one.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state  <= ASSERT;
      cnt    <= '0;
      idx    <= '0;
      rst_o  <= '1;
      busy_o <= 1'b1;
      done_o <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      idx    <= idx_n;
      rst_o  <= rst_n;
      busy_o <= (state != IDLE);
      done_o <= (state == IDLE) && busy_o;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed + randomized bench for reset_sequencer against a time-since-request model.
module tb_reset_sequencer;

  localparam int STAGES = 2, CHANNELS = 4, HOLD = 8, GAP = 4;

  logic       clk = 1'b0;
  logic       rst_i, async_rst_i, sw_rst_i;
  logic [3:0] rst_o;
  logic       busy_o, done_o;
`ifdef RESET_SEQ_ACK_EN
  logic [3:0] ack_i;
`endif

  int passed = 0, total = 0, dones = 0;

  // Model: quiet = edges since the last request; released channels follow from it.
  int              quiet = 0;
  bit              active = 1'b1, pend_done = 1'b0, exp_busy = 1'b1, exp_done = 1'b0;
  bit [STAGES-1:0] ahist = '0;
  logic [3:0]      exp_rst = 4'hF;

  always #5 clk = ~clk;

  reset_sequencer #(.STAGES(STAGES), .CHANNELS(CHANNELS), .HOLD(HOLD), .GAP(GAP)) dut (
    .clk         (clk),
    .rst_i       (rst_i),
    .async_rst_i (async_rst_i),
    .sw_rst_i    (sw_rst_i),
`ifdef RESET_SEQ_ACK_EN
    .ack_i       (ack_i),
`endif
    .rst_o       (rst_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  function automatic logic [3:0] pattern(input int q);
    int r;
    logic [3:0] ones = 4'hF;
    r = (q < HOLD) ? 0 : 1 + (q - HOLD) / GAP;
    if (r > CHANNELS) r = CHANNELS;
    return ones << r;
  endfunction

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick(input bit r, input bit a, input bit s, input bit use_model);
    bit req, was_active;
    rst_i = r; async_rst_i = a; sw_rst_i = s;
    @(posedge clk);
    req        = ahist[STAGES-1] | s;
    was_active = active;
    exp_done   = pend_done;
    pend_done  = 1'b0;
    exp_busy   = was_active;
    if (r) begin
      ahist = '0; quiet = 0; active = 1'b1; exp_busy = 1'b1; exp_done = 1'b0;
    end else begin
      ahist = {ahist[STAGES-2:0], a};
      if (req) begin
        quiet = 0; active = 1'b1;
      end else if (active) begin
        quiet++;
        if (pattern(quiet) == 4'h0) begin active = 1'b0; pend_done = 1'b1; end
      end
    end
    exp_rst = active ? pattern(quiet) : 4'h0;
    #1;
    if (done_o === 1'b1) dones++;
    if (use_model) begin
      chk("rst_o", rst_o, exp_rst);
      chk("busy_o", 4'(busy_o), 4'(exp_busy));
      chk("done_o", 4'(done_o), 4'(exp_done));
    end
  endtask

  // Quiet run after a request: checks the release cadence and a single done pulse.
  task automatic run_seq(input string tag);
    dones = 0;
    for (int i = 0; i < 23; i++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      if (i == 7)  chk({tag, " E"}, rst_o, 4'hE);
      if (i == 11) chk({tag, " C"}, rst_o, 4'hC);
      if (i == 15) chk({tag, " 8"}, rst_o, 4'h8);
      if (i == 19) chk({tag, " 0"}, rst_o, 4'h0);
      if (i == 20) chk({tag, " done"}, 4'(done_o), 4'h1);
    end
    chk({tag, " done count"}, 4'(dones), 4'd1);
  endtask

  initial begin
    bit a_lvl;
    rst_i = 1'b1; async_rst_i = 1'b0; sw_rst_i = 1'b0;
`ifdef RESET_SEQ_ACK_EN
    ack_i = 4'hF;
`endif
    repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b1);
    chk("reset rst_o", rst_o, 4'hF);
    chk("reset busy", 4'(busy_o), 4'h1);
    run_seq("por");

    tick(1'b0, 1'b0, 1'b1, 1'b1);
    chk("sw latency", rst_o, 4'hF);
    run_seq("sw");

    #4;
    async_rst_i = 1'b1;
    tick(1'b0, 1'b1, 1'b0, 1'b1);
    chk("async edge1", rst_o, 4'h0);
    tick(1'b0, 1'b1, 1'b0, 1'b1);
    chk("async edge2", rst_o, 4'h0);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    chk("async latency", rst_o, 4'hF);
    repeat (25) tick(1'b0, 1'b0, 1'b0, 1'b1);

    tick(1'b0, 1'b0, 1'b1, 1'b1);
    dones = 0;
    repeat (12) tick(1'b0, 1'b0, 1'b0, 1'b1);
    chk("abort pre", rst_o, 4'hC);
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    chk("abort rst", rst_o, 4'hF);
    chk("abort no done", 4'(dones), 4'd0);
    run_seq("abort");

    tick(1'b0, 1'b0, 1'b1, 1'b1);
    repeat (14) tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    chk("mid rst", rst_o, 4'hF);
    chk("mid busy", 4'(busy_o), 4'h1);
    run_seq("mid");

`ifdef RESET_SEQ_ACK_EN
    ack_i = 4'b0001;
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (12) tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("ack C", rst_o, 4'hC);
    repeat (20) tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("ack stall", rst_o, 4'hC);
    ack_i = 4'b0011;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("ack release", rst_o, 4'h8);
    ack_i = 4'hF;
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    run_seq("ack resync");
`endif

    a_lvl = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) == 0) a_lvl = ~a_lvl;
      tick($urandom_range(0, 399) == 0, a_lvl, $urandom_range(0, 79) == 0, 1'b1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
